// File: rtl/noise_pkg.sv
// Shared types, constants and helpers for the audio noise injector.
package noise_pkg;

  // Run-time noise source select; the fourth encoding behaves like NOISE_OFF.
  typedef enum logic [1:0] {
    NOISE_OFF  = 2'b00,
    NOISE_SAW  = 2'b01,
    NOISE_LFSR = 2'b10
  } noise_mode_e;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci feedback taps (bit indices) for x^16 + x^14 + x^13 + x^11 + 1.
  localparam int TAP_0 = 15;
  localparam int TAP_1 = 13;
  localparam int TAP_2 = 12;
  localparam int TAP_3 = 10;

  // Working width of the saturating adder; callers sign-extend into it.
  localparam int SAT_W = 64;

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
    int k;
    k = n % 16;
    return (v << k) | (v >> (16 - k));
  endfunction

  // Signed add of two sign-extended operands, clamped to a w-bit two's
  // complement range. w must stay well below SAT_W so the raw sum cannot wrap.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int w);
    logic signed [SAT_W-1:0] s, hi, lo;
    s  = signed'(a) + signed'(b);
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/noise_lfsr.sv
// One channel's noise generators: a free-running sawtooth counter and a
// 16-bit Fibonacci LFSR. Both step only when advance is high.
module noise_lfsr
  import noise_pkg::*;
#(
  parameter int NOISE_W = 3,
  parameter int LFSR_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               advance,
  input  logic [LFSR_W-1:0]  seed,
  output logic [NOISE_W-1:0] saw,
  output logic [LFSR_W-1:0]  lfsr
);

  logic fb;
  assign fb = lfsr[TAP_0] ^ lfsr[TAP_1] ^ lfsr[TAP_2] ^ lfsr[TAP_3];

  // Generators hold between samples so a mode switch never restarts them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      saw  <= '0;
      lfsr <= seed;
    end else if (advance) begin
      saw  <= saw + 1'b1;
      lfsr <= {lfsr[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/noise_injector.sv
// Per-channel noise generation, amplitude shift and saturating mix into
// the audio sample stream. Two-stage pipeline, no backpressure.
module noise_injector
  import noise_pkg::*;
#(
  parameter int                 WIDTH    = 24,
  parameter int                 CHANNELS = 2,
  parameter int                 NOISE_W  = 3,
  parameter int                 LFSR_W   = 16,
  parameter logic [LFSR_W-1:0]  SEED     = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 mode,
  input  logic [4:0]                 level,
  input  logic                       in_valid,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  output logic                       out_valid,
  output logic [CHANNELS*WIDTH-1:0]  out_data,
  output logic [CHANNELS*WIDTH-1:0]  noise_out
);

  localparam int MAX_LVL = WIDTH - NOISE_W;
  localparam int STAGES  = 2;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] chan_vec_t;

  chan_vec_t in_vec, n_vec, s1_data, s1_noise, sum_vec, out_vec, nout_vec;
  logic [4:0] lvl;
  logic [STAGES:1] vld_pipe;

  assign in_vec = in_data;

  // Clamp the shift so the sign-extended noise can never overflow WIDTH.
  always_comb begin
    lvl = level;
    if (int'(level) > MAX_LVL) lvl = 5'(MAX_LVL);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [LFSR_W-1:0] CH_SEED = rotl16(SEED, c);

    logic [NOISE_W-1:0] saw;
    logic [LFSR_W-1:0]  lfsr_unused;
    logic [NOISE_W-1:0] raw;

    noise_lfsr #(.NOISE_W(NOISE_W), .LFSR_W(LFSR_W)) u_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .advance (in_valid),
      .seed    (CH_SEED),
      .saw     (saw),
      .lfsr    (lfsr_unused)
    );

    // Raw signed noise word from the selected source; reserved mode is silent.
    always_comb begin
      raw = '0;
      case (mode)
        NOISE_SAW:  raw = saw;
        NOISE_LFSR: raw = lfsr_unused[LFSR_W-1 -: NOISE_W];
        default:    raw = '0;
      endcase
    end

    assign n_vec[c]   = {{(WIDTH-NOISE_W){raw[NOISE_W-1]}}, raw} << lvl;
    assign sum_vec[c] = WIDTH'(sat_add(SAT_W'(signed'(s1_data[c])),
                                       SAT_W'(signed'(s1_noise[c])), WIDTH));
  end

  // Valid shift register; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Stage 1: capture samples with noise built from this edge's mode/level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_data  <= '0;
      s1_noise <= '0;
    end else if (in_valid) begin
      s1_data  <= in_vec;
      s1_noise <= n_vec;
    end
  end

  // Stage 2: register the saturated mix; outputs hold between strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_vec  <= '0;
      nout_vec <= '0;
    end else if (vld_pipe[1]) begin
      out_vec  <= sum_vec;
      nout_vec <= s1_noise;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = out_vec;
  assign noise_out = nout_vec;

endmodule

// File: tb/tb_noise_injector.sv
// Scoreboard bench for noise_injector: two instances (NOISE_W=3 and 16)
// share stimulus; a behavioural model queues expected outputs at issue time.
module tb_noise_injector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  level = 5'd0;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = '0;
  logic        ov3, ov16;
  logic [47:0] od3, on3, od16, on16;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [47:0] d3, n3, d16, n16;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] m_saw[2];
  logic [15:0] m_lfsr[2];
  logic [23:0] saw_exp[9] = '{24'h000000, 24'h000800, 24'h001000, 24'h001800,
                              24'hFFE000, 24'hFFE800, 24'hFFF000, 24'hFFF800,
                              24'h000000};

  noise_injector #(.NOISE_W(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .level(level),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov3), .out_data(od3), .noise_out(on3)
  );

  noise_injector #(.NOISE_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .level(level),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov16), .out_data(od16), .noise_out(on16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx24(input logic [23:0] d);
    longint v;
    v = longint'(d);
    if (d[23]) v = v - (longint'(1) << 24);
    return v;
  endfunction

  function automatic logic [23:0] sat24(input longint s);
    if (s > 64'sd8388607)  return 24'h7FFFFF;
    if (s < -64'sd8388608) return 24'h800000;
    return 24'(s);
  endfunction

  function automatic longint mnoise(input int nw, input logic [1:0] md, input logic [4:0] lv,
                                    input logic [15:0] sw, input logic [15:0] lf);
    longint raw;
    int     sh;
    raw = 0;
    if (md == 2'd1)      raw = longint'(sw) & ((longint'(1) << nw) - 1);
    else if (md == 2'd2) raw = longint'(lf >> (16 - nw));
    if (raw >= (longint'(1) << (nw - 1))) raw = raw - (longint'(1) << nw);
    sh = (int'(lv) > 24 - nw) ? 24 - nw : int'(lv);
    return raw * (longint'(1) << sh);
  endfunction

  task automatic model_reset();
    logic [15:0] x;
    for (int c = 0; c < 2; c++) begin
      x = 16'hACE1;
      repeat (c) x = {x[14:0], x[15]};
      m_saw[c]  = '0;
      m_lfsr[c] = x;
    end
  endtask

  // Drive one sample set at the current time and queue its expected result.
  task automatic issue(input logic [1:0] md, input logic [4:0] lv,
                       input logic [23:0] l, input logic [23:0] r);
    exp_t        e;
    longint      n;
    logic [23:0] d[2];
    d[0] = l;
    d[1] = r;
    mode = md; level = lv; in_data = {r, l}; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n = mnoise(3, md, lv, m_saw[c], m_lfsr[c]);
      e.n3[c*24 +: 24] = 24'(n);
      e.d3[c*24 +: 24] = sat24(sx24(d[c]) + n);
      n = mnoise(16, md, lv, m_saw[c], m_lfsr[c]);
      e.n16[c*24 +: 24] = 24'(n);
      e.d16[c*24 +: 24] = sat24(sx24(d[c]) + n);
      m_saw[c]  = m_saw[c] + 16'd1;
      m_lfsr[c] = {m_lfsr[c][14:0],
                   m_lfsr[c][15] ^ m_lfsr[c][13] ^ m_lfsr[c][12] ^ m_lfsr[c][10]};
    end
    e.stamp = cyc + 2;
    q.push_back(e);
  endtask

  // Single isolated sample; returns with its result on the outputs.
  task automatic run1(input logic [1:0] md, input logic [4:0] lv,
                      input logic [23:0] l, input logic [23:0] r);
    @(negedge clk) issue(md, lv, l, r);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    model_reset();
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: any valid, or an overdue expectation, consumes an entry.
  always @(negedge clk) begin
    if (ov3 || ov16 || (q.size() > 0 && q[0].stamp <= cyc)) begin
      if (q.size() == 0) begin
        chk("spurious_ov", {62'd0, ov3, ov16}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("ov3", ov3, 1);
        chk("ov16", ov16, 1);
        chk("latency", cyc, mon_e.stamp);
        chk("sb_data3", od3, mon_e.d3);
        chk("sb_noise3", on3, mon_e.n3);
        chk("sb_data16", od16, mon_e.d16);
        chk("sb_noise16", on16, mon_e.n16);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();

    // Reset state and pass-through
    do_reset(3);
    chk("rst_ov", {ov3, ov16}, 0);
    chk("rst_data", od3 | od16, 0);
    chk("rst_noise", on3 | on16, 0);
    @(negedge clk) issue(2'd0, 5'd0, 24'h123456, 24'hFEDCBA);
    @(negedge clk) in_valid = 1'b0;
    chk("pt_early", ov3, 0);
    @(negedge clk);
    chk("pt_ov", ov3, 1);
    chk("pt_data", od3, 48'hFEDCBA123456);
    chk("pt_noise", on3, 0);
    @(negedge clk);
    chk("pt_ov_fall", ov3, 0);
    chk("pt_hold", od3, 48'hFEDCBA123456);

    // Sawtooth, back-to-back
    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 9) issue(2'd1, 5'd11, 24'h0, 24'h0);
      else       in_valid = 1'b0;
      if (i >= 2) begin
        chk("saw_ov", ov3, 1);
        chk("saw_ch0", od3[23:0], saw_exp[i-2]);
        chk("saw_ch1", od3[47:24], saw_exp[i-2]);
      end
    end

    // LFSR sequence on the 16-bit noise instance
    do_reset(2);
    @(negedge clk) issue(2'd2, 5'd0, 24'h0, 24'h0);
    @(negedge clk) issue(2'd2, 5'd0, 24'h0, 24'h0);
    @(negedge clk) in_valid = 1'b0;
    chk("lfsr_ch0_a", on16[23:0], 24'hFFACE1);
    chk("lfsr_ch1_a", on16[47:24], 24'h0059C3);
    @(negedge clk);
    chk("lfsr_ch0_b", on16[23:0], 24'h0059C3);
    chk("lfsr_data_b", od16[23:0], 24'h0059C3);

    // Saturation at both rails
    do_reset(2);
    run1(2'd1, 5'd8, 24'h0, 24'h0);
    run1(2'd1, 5'd8, 24'h7FFFF0, 24'h0);
    chk("sat_hi", od3[23:0], 24'h7FFFFF);
    run1(2'd1, 5'd8, 24'h0, 24'h0);
    run1(2'd1, 5'd8, 24'h0, 24'h0);
    run1(2'd1, 5'd8, 24'h800010, 24'h0);
    chk("sat_lo", od3[23:0], 24'h800000);

    // Idle gaps, mode switching, reserved mode, level clamp
    do_reset(2);
    run1(2'd1, 5'd11, 24'h0, 24'h0);
    repeat (5) @(negedge clk);
    run1(2'd1, 5'd11, 24'h0, 24'h0);
    chk("gap_hold", on3[23:0], 24'h000800);
    repeat (5) @(negedge clk);
    run1(2'd2, 5'd11, 24'h0, 24'h0);
    run1(2'd1, 5'd11, 24'h0, 24'h0);
    chk("mode_resume", on3[23:0], 24'h001800);
    run1(2'd3, 5'd11, 24'h0, 24'h0);
    chk("reserved_off", on3 | on16, 0);
    run1(2'd1, 5'd31, 24'h0, 24'h0);
    chk("level_clamp", on3[23:0], 24'hA00000);

    // Reset one cycle after a strobe drops the sample and reloads seeds
    @(negedge clk) issue(2'd2, 5'd0, 24'h111111, 24'h222222);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("mr_ov", {ov3, ov16}, 0);
    chk("mr_data", od3 | od16, 0);
    chk("mr_noise", on3 | on16, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("mr_no_ov", {ov3, ov16}, 0);
    run1(2'd2, 5'd0, 24'h0, 24'h0);
    chk("mr_seed_ch0", on16[23:0], 24'hFFACE1);
    chk("mr_seed_ch1", on16[47:24], 24'h0059C3);

    repeat (4) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
